// File: rtl/fft_output_reorder.sv
// -----------------------------------------------------------------------------
// fft_output_reorder
//
// Purpose:
//   Sits on the FFT core output, which delivers each N-sample frame in
//   bit-reversed bin order. Each frame is buffered in a ping-pong RAM and
//   re-emitted in natural bin order (0..N-1). The same en/re/im streaming
//   handshake is used on both sides, so the block chains directly.
//
// Ports:
//   clock    in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset
//   di_en    in   1      input sample valid (FFT do_en)
//   di_re    in   WIDTH  input real part, bit-reversed bin order
//   di_im    in   WIDTH  input imaginary part
//   do_en    out  1      output sample valid
//   do_re    out  WIDTH  output real part, natural bin order
//   do_im    out  WIDTH  output imaginary part
//   do_sof   out  1      first sample of each output frame
//   overflow out  1      sticky: an input sample was dropped (no free bank)
//
// Configuration:
//   FFT_REORDER_FFTSHIFT_EN  when defined, frames are emitted DC-centred
//                            (bins N/2..N-1, 0..N/2-1); do_sof marks bin N/2.
// -----------------------------------------------------------------------------
module fft_output_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_sof,
    output logic             overflow
);

    localparam int N = 1 << LOG2N;

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } state_t;

    // Two banks of N words, bank select is the address MSB.
    logic [2*WIDTH-1:0] mem_q [2*N];

    state_t           state_q, state_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic [1:0]       full_q, full_d;
    logic             overflow_q, overflow_d;

    logic             rd_en;
    logic             rd_release;
    logic             wr_en;
    logic [LOG2N-1:0] rd_addr;

    logic             do_en_q;
    logic             do_sof_q;
    logic [WIDTH-1:0] do_re_q;
    logic [WIDTH-1:0] do_im_q;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Read FSM and write bookkeeping (next-state logic)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path leaves a signal unassigned (no latch).
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        rbank_d    = rbank_q;
        wcnt_d     = wcnt_q;
        wbank_d    = wbank_q;
        full_d     = full_q;
        overflow_d = overflow_q;

        rd_en      = (state_q == ST_READ);
        rd_release = rd_en && (&rcnt_q);

`ifdef FFT_REORDER_FFTSHIFT_EN
        rd_addr = bitrev(rcnt_q ^ LOG2N'(N / 2));
`else
        rd_addr = bitrev(rcnt_q);
`endif

        // A bank being released this cycle may already take the next frame's
        // first sample; the reader has read that word long ago. This keeps
        // back-to-back frames at 1 sample/clk free of overflow.
        wr_en = di_en && (!full_q[wbank_q] || (rd_release && (rbank_q == wbank_q)));

        if (di_en && !wr_en) begin
            overflow_d = 1'b1;
        end

        if (wr_en) begin
            wcnt_d = wcnt_q + LOG2N'(1);
            if (&wcnt_q) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                rcnt_d = '0;
                if (full_q[rbank_q]) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rcnt_d = rcnt_q + LOG2N'(1);
                if (rd_release) begin
                    // Reader's clear is applied after the writer's set: on a
                    // same-bank collision the release wins.
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                    // Uses the registered flag, so a bank filled on this very
                    // edge is picked up from IDLE one cycle later.
                    if (!full_q[~rbank_q]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= '0;
            rbank_q    <= 1'b0;
            wcnt_q     <= '0;
            wbank_q    <= 1'b0;
            full_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            rbank_q    <= rbank_d;
            wcnt_q     <= wcnt_d;
            wbank_q    <= wbank_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample RAM
    // ------------------------------------------------------------------
    // NOTE: the RAM array has no reset so it maps onto block RAM; the full
    // flags, not the contents, decide what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[{wbank_q, wcnt_q}] <= {di_re, di_im};
        end
    end

    // ------------------------------------------------------------------
    // Registered read / output stage; data holds while do_en is low
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            do_en_q  <= 1'b0;
            do_sof_q <= 1'b0;
            do_re_q  <= '0;
            do_im_q  <= '0;
        end else begin
            do_en_q  <= rd_en;
            do_sof_q <= rd_en && (rcnt_q == '0);
            if (rd_en) begin
                {do_re_q, do_im_q} <= mem_q[{rbank_q, rd_addr}];
            end
        end
    end

    assign do_en    = do_en_q;
    assign do_sof   = do_sof_q;
    assign do_re    = do_re_q;
    assign do_im    = do_im_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_output_reorder
//
// Self-checking bench for fft_output_reorder. Stimulus pushes expected output
// samples into a scoreboard queue when a frame completes; a separate monitor
// pops and compares every do_en cycle. Define FFT_REORDER_FFTSHIFT_EN for both
// bench and RTL to check the DC-centred build.
// -----------------------------------------------------------------------------
module tb_fft_output_reorder;

    localparam int WIDTH = 16;
    localparam int LOG2N = 6;
    localparam int N     = 1 << LOG2N;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             sof;
    } sample_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             di_en = 1'b0;
    logic [WIDTH-1:0] di_re = '0;
    logic [WIDTH-1:0] di_im = '0;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_sof;
    logic             overflow;

    fft_output_reorder #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clock    (clock),
        .reset    (reset),
        .di_en    (di_en),
        .di_re    (di_re),
        .di_im    (di_im),
        .do_en    (do_en),
        .do_re    (do_re),
        .do_im    (do_im),
        .do_sof   (do_sof),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    sample_t exp_q[$];

    // Reference model state: samples of the frame being received, in arrival order.
    logic [WIDTH-1:0] frame_re [N];
    logic [WIDTH-1:0] frame_im [N];
    int               frame_cnt = 0;

    // Monitor bookkeeping
    logic [WIDTH-1:0] last_re = '0;
    logic [WIDTH-1:0] last_im = '0;
    int               run     = 0;
    int               max_run = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if (((v >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
        end
        return r;
    endfunction

    // Arrival j carries bin brev(j). Emit bins in natural (or DC-centred) order.
    task automatic model_frame_done();
        logic [WIDTH-1:0] bin_re [N];
        logic [WIDTH-1:0] bin_im [N];
        sample_t s;
        int b;
        for (int j = 0; j < N; j++) begin
            bin_re[brev(j)] = frame_re[j];
            bin_im[brev(j)] = frame_im[j];
        end
        for (int k = 0; k < N; k++) begin
`ifdef FFT_REORDER_FFTSHIFT_EN
            b = (k + N / 2) % N;
`else
            b = k;
`endif
            s.re  = bin_re[b];
            s.im  = bin_im[b];
            s.sof = (k == 0);
            exp_q.push_back(s);
        end
    endtask

    // Drive one valid sample; returns 1 ns after the edge that captured it.
    task automatic send(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        di_en = 1'b1;
        di_re = re;
        di_im = im;
        @(posedge clock);
        #1;
        di_en = 1'b0;
        frame_re[frame_cnt] = re;
        frame_im[frame_cnt] = im;
        frame_cnt++;
        if (frame_cnt == N) begin
            frame_cnt = 0;
            model_frame_done();
        end
    endtask

    task automatic idle_cycle();
        di_en = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        check(name, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clock);
        #1;
    endtask

    // Monitor: scoreboard pop on every valid output, hold check otherwise.
    always @(negedge clock) begin
        if (reset) begin
            last_re = '0;
            last_im = '0;
            run     = 0;
        end else if (do_en) begin
            sample_t e;
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1'b0, 64'({do_re, do_im, do_sof}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_sample", {do_re, do_im, do_sof} == e,
                      64'({do_re, do_im, do_sof}), 64'(e));
            end
            last_re = do_re;
            last_im = do_im;
        end else begin
            run = 0;
            check("hold_data", {do_re, do_im, do_sof} == {last_re, last_im, 1'b0},
                  64'({do_re, do_im, do_sof}), 64'({last_re, last_im, 1'b0}));
        end
    end

    initial begin
        // Test 1: reset held 5 clocks, outputs zero throughout and just after release.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("reset_outputs", {do_en, do_sof, do_re, do_im, overflow} == '0,
                  64'({do_en, do_sof, do_re, do_im, overflow}), 64'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_outputs", {do_en, do_sof, do_re, do_im, overflow} == '0,
              64'({do_en, do_sof, do_re, do_im, overflow}), 64'd0);
        @(posedge clock);
        #1;

        // Test 2: single frame, re=bitrev(j), im=-bitrev(j); check latency.
        max_run = 0;
        for (int j = 0; j < N; j++) begin
            send(WIDTH'(brev(j)), WIDTH'(-brev(j)));
        end
        @(negedge clock);
        check("latency_edge1", do_en == 1'b0, 64'(do_en), 64'd0);
        @(negedge clock);
        check("latency_edge2", do_en == 1'b0, 64'(do_en), 64'd0);
        @(negedge clock);
        check("latency_first", {do_en, do_sof} == 2'b11, 64'({do_en, do_sof}), 64'd3);
        wait_drain("drain_single");
        check("single_run", max_run == N, 64'(max_run), 64'(N));

        // Test 3: three frames back to back, must come out as one continuous burst.
        max_run = 0;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < N; j++) begin
                send(WIDTH'(64 * f + brev(j)), WIDTH'(-(64 * f + brev(j))));
            end
        end
        wait_drain("drain_b2b");
        check("b2b_run", max_run == 3 * N, 64'(max_run), 64'(3 * N));
        check("b2b_overflow", overflow == 1'b0, 64'(overflow), 64'd0);

        // Test 4: di_en alternating 1,0.
        for (int j = 0; j < N; j++) begin
            send(WIDTH'(brev(j)), WIDTH'(-brev(j)));
            idle_cycle();
        end
        wait_drain("drain_gapped");

        // Test 5: reset after 40 samples, then one full frame.
        for (int j = 0; j < 40; j++) begin
            send(WIDTH'($urandom), WIDTH'($urandom));
        end
        reset = 1'b1;
        frame_cnt = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        max_run = 0;
        for (int j = 0; j < N; j++) begin
            send(WIDTH'(brev(j)), WIDTH'(-brev(j)));
        end
        wait_drain("drain_after_reset");
        check("after_reset_run", max_run == N, 64'(max_run), 64'(N));

        // Random data with random gaps, two frames.
        for (int j = 0; j < 2 * N; j++) begin
            send(WIDTH'($urandom), WIDTH'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        wait_drain("drain_random");
        check("final_overflow", overflow == 1'b0, 64'(overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
